mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, consecutive data grants allowed while fetch waits.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports if_req input 1, if_addr input ADDR_W: fetch read request and address.
REQ-007 SHALL have ports if_gnt output 1, if_rvalid output 1, if_rdata output DATA_W: fetch accept pulse, read-data pulse, read data.
REQ-008 SHALL have ports dm_req input 1, dm_we input 1, dm_addr input ADDR_W, dm_wdata input DATA_W, dm_be input DATA_W/8: data-stage request.
REQ-009 SHALL have ports dm_gnt output 1, dm_rvalid output 1, dm_rdata output DATA_W: data accept pulse, load-data pulse, load data.
REQ-010 SHALL have ports mem_req output 1, mem_we output 1, mem_addr output ADDR_W, mem_wdata output DATA_W, mem_be output DATA_W/8: single shared memory port.
REQ-011 SHALL have ports mem_ready input 1, mem_rvalid input 1, mem_rdata input DATA_W: memory accept and read return.
REQ-012 SHALL have port busy output 1, high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT_R; one transaction outstanding at most.
REQ-014 IDLE: if any request, SHALL select a winner, latch its addr/we/wdata/be and owner, pulse that requester's gnt for exactly one cycle, go to ISSUE next cycle.
REQ-015 Selection SHALL grant dm when dm_req=1 unless if_req=1 and starve_cnt==STARVE_MAX, in which case if is granted.
REQ-016 starve_cnt SHALL increment (saturating at STARVE_MAX) on each dm grant while if_req=1, and clear to 0 on each if grant.
REQ-017 Fetch requests SHALL always drive mem_we=0 and mem_be all ones.
REQ-018 ISSUE: mem_req=1 with latched fields held stable until the cycle mem_ready=1.
REQ-019 On mem_ready in ISSUE: write SHALL return to IDLE next cycle; read SHALL go to WAIT_R.
REQ-020 WAIT_R: on mem_rvalid=1 SHALL, in that same cycle (combinational), assert owner's rvalid for one cycle with rdata=mem_rdata, then return to IDLE.
REQ-021 Non-owner rvalid SHALL stay 0; if_rdata/dm_rdata may carry mem_rdata unconditionally.
REQ-022 mem_rvalid outside WAIT_R SHALL be ignored.
REQ-023 Requester SHALL hold req and fields until its gnt; arbiter latches at gnt, so fields may change afterwards.
REQ-024 Latency: read SHALL take min 3 cycles req-to-rvalid (grant, issue with mem_ready=1, rvalid); write min 2 cycles to IDLE.
REQ-025 New requests during ISSUE/WAIT_R SHALL wait; no gnt issued outside IDLE.

Reset
REQ-026 When rst=0 at a clock edge SHALL force IDLE, starve_cnt=0, latched fields 0; any in-flight transaction is dropped with no rvalid.
REQ-027 During reset all outputs SHALL be 0: gnts, rvalids, mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy.

Verification
REQ-028 Fetch only: if_req, if_addr=0x10, mem_ready=1, mem_rvalid next cycle with 0x00500093 -> if_gnt pulse, mem_addr=0x10, if_rvalid with if_rdata=0x00500093, busy drops after.
REQ-029 Store: dm_req, dm_we=1, dm_addr=0x12, dm_wdata=99, dm_be=0xF, mem_ready delayed 3 cycles -> mem fields held 3 cycles, no dm_rvalid, IDLE after acceptance.
REQ-030 Simultaneous if_req and dm_req, both held continuously -> 4 dm grants then 1 if grant (STARVE_MAX=4), starve_cnt returns to 0.
REQ-031 Load with mem_rvalid stray pulse during ISSUE -> ignored; dm_rvalid only on rvalid in WAIT_R, if_rvalid never.
REQ-032 rst=0 asserted in WAIT_R, then mem_rvalid=1 -> no rvalid output, state IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// (if_*) and a data-stage requester (dm_*). At most one transaction is in
// flight. Data requests normally win; a waiting fetch is forced through once
// STARVE_MAX consecutive data grants have gone by while it was waiting.
//
// Ports
//   clk, rst                     clock, synchronous active-low reset
//   if_req/if_addr               fetch read request
//   if_gnt/if_rvalid/if_rdata    fetch accept pulse, read-data pulse, data
//   dm_req/we/addr/wdata/be      data-stage request
//   dm_gnt/dm_rvalid/dm_rdata    data accept pulse, load-data pulse, data
//   mem_req/we/addr/wdata/be     shared memory request (held until mem_ready)
//   mem_ready/rvalid/rdata       memory accept and read return
//   busy                         high whenever a transaction is in progress
//
// state  | meaning
// IDLE   | no transaction; pick a winner, latch its fields, pulse its gnt
// ISSUE  | mem_req driven with latched fields until mem_ready
// WAIT_R | read accepted; waiting for mem_rvalid to return data to the owner
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    starve_cnt;
  logic                owner_dm;
  logic                gnt_if_q;
  logic                gnt_dm_q;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [BE_W-1:0]     lat_be;
  logic                pick_if;
  logic                rd_done;

  // Fetch wins only when data is absent or the fetch has been starved enough.
  assign pick_if = if_req && (!dm_req || (starve_cnt == CNT_MAX));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      owner_dm   <= 1'b0;
      gnt_if_q   <= 1'b0;
      gnt_dm_q   <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
    end else begin
      gnt_if_q <= 1'b0;
      gnt_dm_q <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            state <= ISSUE;
            if (pick_if) begin
              owner_dm   <= 1'b0;
              gnt_if_q   <= 1'b1;
              lat_we     <= 1'b0;
              lat_addr   <= if_addr;
              lat_wdata  <= '0;
              lat_be     <= '1;
              starve_cnt <= '0;
            end else begin
              owner_dm  <= 1'b1;
              gnt_dm_q  <= 1'b1;
              lat_we    <= dm_we;
              lat_addr  <= dm_addr;
              lat_wdata <= dm_wdata;
              lat_be    <= dm_be;
              // Only data grants that bypass a waiting fetch count as starving it.
              if (if_req && (starve_cnt != CNT_MAX))
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
          end
        end
        ISSUE: begin
          if (mem_ready)
            state <= lat_we ? IDLE : WAIT_R;
        end
        WAIT_R: begin
          if (mem_rvalid)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Every output is forced low while rst is held, even before the reset edge,
  // so a read return arriving during reset never reaches a requester.
  assign rd_done   = rst && (state == WAIT_R) && mem_rvalid;
  assign if_gnt    = rst && gnt_if_q;
  assign dm_gnt    = rst && gnt_dm_q;
  assign if_rvalid = rd_done && !owner_dm;
  assign dm_rvalid = rd_done && owner_dm;
  assign if_rdata  = rst ? mem_rdata : '0;
  assign dm_rdata  = rst ? mem_rdata : '0;
  assign mem_req   = rst && (state == ISSUE);
  assign mem_we    = rst && lat_we;
  assign mem_addr  = rst ? lat_addr : '0;
  assign mem_wdata = rst ? lat_wdata : '0;
  assign mem_be    = rst ? lat_be : '0;
  assign busy      = rst && (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [BW-1:0] dm_be = '0;
  logic          dm_gnt, dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct { int due; bit is_if; } gnt_exp_t;
  typedef struct { int due; bit is_if; logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; logic [BW-1:0] be; } mem_exp_t;
  typedef struct { int due; bit is_if; logic [DW-1:0] data; } rv_exp_t;

  gnt_exp_t gq[$];
  mem_exp_t mq[$];
  rv_exp_t  rq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int ph = 0;       // transaction phase for the coming cycle: 0 none, 1 address, 2 awaiting data
  int ph_now = 0;   // phase during the current cycle
  int starve = 0;
  bit cur_if = 1'b0;
  bit cur_we = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, busy} == 7'b0, tag,
        64'({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, busy}), 64'd0);
    chk(mem_addr == '0 && mem_wdata == '0 && mem_be == '0, {tag, "_fields"},
        64'({mem_addr, mem_be}), 64'd0);
  endtask

  task automatic wait_gnt(input bit want_if);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!(want_if ? if_gnt : dm_gnt) && n < 20);
    chk(want_if ? if_gnt : dm_gnt, "gnt_wait", 64'(n), 64'd20);
  endtask

  task automatic quiesce();
    if_req = 1'b1 & if_req;
    repeat (20) begin
      cycle();
      if (if_req && if_gnt) if_req = 1'b0;
      if (dm_req && dm_gnt) dm_req = 1'b0;
      mem_ready  = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
    end
    cycle();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    cycle();
  endtask

  // Reference model: transaction-level view of the arbitration rules,
  // driven only by what the bench itself applies to the inputs.
  initial begin : model
    mem_exp_t m;
    bit take_if;
    forever begin
      @(negedge clk);
      ph_now = ph;
      if (!chk_en) begin
        ph = 0;
        starve = 0;
      end else begin
        case (ph)
          0: if (if_req || dm_req) begin
            take_if = if_req && (!dm_req || starve == SM);
            m.due   = cyc + 1;
            m.is_if = take_if;
            if (take_if) begin
              m.addr = if_addr; m.we = 1'b0; m.wdata = '0; m.be = '1;
              starve = 0;
            end else begin
              m.addr = dm_addr; m.we = dm_we; m.wdata = dm_wdata; m.be = dm_be;
              if (if_req && starve < SM) starve++;
            end
            gq.push_back('{due: cyc + 1, is_if: take_if});
            mq.push_back(m);
            cur_if = take_if;
            cur_we = m.we;
            ph = 1;
          end
          1: if (mem_ready) ph = cur_we ? 0 : 2;
          2: if (mem_rvalid) begin
            rq.push_back('{due: cyc, is_if: cur_if, data: mem_rdata});
            ph = 0;
          end
          default: ph = 0;
        endcase
      end
    end
  end

  initial begin : monitor
    gnt_exp_t g;
    mem_exp_t m;
    rv_exp_t  r;
    forever begin
      @(negedge clk);
      #1;
      if (chk_en) begin
        if (gq.size() > 0 && gq[0].due == cyc) begin
          g = gq.pop_front();
          chk({if_gnt, dm_gnt} == {g.is_if, ~g.is_if}, "gnt_owner",
              64'({if_gnt, dm_gnt}), 64'({g.is_if, ~g.is_if}));
        end else begin
          chk(!(if_gnt || dm_gnt), "gnt_unexpected", 64'({if_gnt, dm_gnt}), 64'd0);
        end

        if (mq.size() > 0 && mq[0].due <= cyc) begin
          m = mq[0];
          chk(mem_req, "mem_req", 64'(mem_req), 64'd1);
          chk(mem_addr == m.addr, "mem_addr", 64'(mem_addr), 64'(m.addr));
          chk(mem_we == m.we, "mem_we", 64'(mem_we), 64'(m.we));
          chk(mem_be == m.be, "mem_be", 64'(mem_be), 64'(m.be));
          if (m.we) chk(mem_wdata == m.wdata, "mem_wdata", 64'(mem_wdata), 64'(m.wdata));
          if (mem_ready) m = mq.pop_front();
        end else begin
          chk(!mem_req, "mem_req_idle", 64'(mem_req), 64'd0);
        end

        if (rq.size() > 0 && rq[0].due == cyc) begin
          r = rq.pop_front();
          chk(if_rvalid == r.is_if && dm_rvalid == !r.is_if, "rvalid_owner",
              64'({if_rvalid, dm_rvalid}), 64'({r.is_if, !r.is_if}));
          chk((r.is_if ? if_rdata : dm_rdata) == r.data, "rdata",
              64'(r.is_if ? if_rdata : dm_rdata), 64'(r.data));
        end else if (if_rvalid || dm_rvalid || mem_rvalid) begin
          chk(!if_rvalid && !dm_rvalid, "rvalid_stray", 64'({if_rvalid, dm_rvalid}), 64'd0);
        end

        chk(busy == (ph_now != 0), "busy", 64'(busy), 64'(ph_now != 0));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    int n;

    // Reset with every input active: all outputs must stay low.
    if_req = 1'b1; dm_req = 1'b1; mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hdeadbeef;
    repeat (3) begin
      @(negedge clk);
      chk_zero("reset_outputs");
    end
    cycle();
    if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    rst = 1'b1;
    chk_en = 1'b1;
    cycle();

    // Fetch only, memory accepts immediately, data the cycle after.
    mem_ready = 1'b1;
    if_addr = 32'h10; if_req = 1'b1;
    wait_gnt(1'b1);
    if_req = 1'b0; if_addr = 32'hffff_fff0;
    cycle();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
    cycle();
    mem_rvalid = 1'b0;
    repeat (2) cycle();

    // Store with mem_ready held off for three cycles.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h12; dm_wdata = 32'd99; dm_be = 4'hf;
    wait_gnt(1'b0);
    dm_req = 1'b0; dm_addr = 32'h5555; dm_wdata = 32'd7; dm_be = 4'h1;
    repeat (3) cycle();
    mem_ready = 1'b1;
    cycle();
    mem_ready = 1'b0;
    repeat (2) cycle();

    // Load with a stray mem_rvalid while the address is still pending.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20; dm_be = 4'h3;
    wait_gnt(1'b0);
    dm_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hbad0bad0;
    cycle();
    mem_rvalid = 1'b0; mem_ready = 1'b1;
    cycle();
    mem_ready = 1'b0;
    cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    cycle();
    mem_rvalid = 1'b0;
    repeat (2) cycle();

    // Both requesters held continuously: four data grants, then one fetch.
    mem_ready = 1'b1; mem_rvalid = 1'b1;
    if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = $urandom; dm_be = 4'hf;
    k = 0; n = 0;
    while (k < 10 && n < 200) begin
      cycle();
      n++;
      mem_rdata = $urandom;
      if (if_gnt || dm_gnt) begin
        chk(if_gnt == (k % 5 == 4), "starve_order", 64'({if_gnt, dm_gnt}), 64'(k % 5 == 4));
        k++;
        if (if_gnt) if_addr = if_addr + 32'd4;
        if (dm_gnt) begin dm_addr = dm_addr + 32'd4; dm_wdata = $urandom; end
      end
    end
    chk(k == 10, "starve_grants", 64'(k), 64'd10);
    quiesce();

    // Randomized traffic.
    repeat (3000) begin
      cycle();
      if (if_req && if_gnt) if_req = 1'b0;
      if (!if_req) begin
        if_addr = $urandom;
        if ($urandom_range(99) < 35) if_req = 1'b1;
      end
      if (dm_req && dm_gnt) dm_req = 1'b0;
      if (!dm_req) begin
        dm_we = 1'($urandom_range(1));
        dm_addr = $urandom;
        dm_wdata = $urandom;
        dm_be = BW'($urandom);
        if ($urandom_range(99) < 40) dm_req = 1'b1;
      end
      mem_ready  = $urandom_range(99) < 60;
      mem_rvalid = $urandom_range(99) < 40;
      mem_rdata  = $urandom;
    end
    quiesce();

    // Reset while a load waits for data, with data arriving during reset.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_be = 4'hf; mem_ready = 1'b1;
    wait_gnt(1'b0);
    dm_req = 1'b0;
    cycle();
    chk(busy, "load_in_flight", 64'(busy), 64'd1);
    chk_en = 1'b0;
    rst = 1'b0; mem_rvalid = 1'b1; mem_ready = 1'b0; mem_rdata = 32'hcafef00d;
    @(negedge clk);
    chk_zero("rst_in_wait_r");
    cycle();
    @(negedge clk);
    chk_zero("rst_held");
    cycle();
    rst = 1'b1;
    @(negedge clk);
    chk(!if_rvalid && !dm_rvalid && !busy && !mem_req, "after_reset_idle",
        64'({if_rvalid, dm_rvalid, busy, mem_req}), 64'd0);
    cycle();
    mem_rvalid = 1'b0;
    gq.delete(); mq.delete(); rq.delete();
    chk_en = 1'b1;
    cycle();

    // Recovery: a short burst of random traffic after the reset.
    repeat (300) begin
      cycle();
      if (if_req && if_gnt) if_req = 1'b0;
      if (!if_req) begin
        if_addr = $urandom;
        if ($urandom_range(99) < 30) if_req = 1'b1;
      end
      if (dm_req && dm_gnt) dm_req = 1'b0;
      if (!dm_req) begin
        dm_we = 1'($urandom_range(1));
        dm_addr = $urandom;
        dm_wdata = $urandom;
        dm_be = BW'($urandom);
        if ($urandom_range(99) < 30) dm_req = 1'b1;
      end
      mem_ready  = $urandom_range(99) < 70;
      mem_rvalid = $urandom_range(99) < 50;
      mem_rdata  = $urandom;
    end
    quiesce();

    chk(gq.size() == 0 && mq.size() == 0 && rq.size() == 0, "queues_drained",
        64'(gq.size() + mq.size() + rq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
